// File: rtl/s8sp_pkg.sv
// Shared constants for the S8SP instruction-fetch path: state encoding,
// data width, default halt opcode and the timeout-counter width helper.
package s8sp_pkg;

    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] HALT_OP_DEF = 8'hFF;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_EXEC = 3'd3;
    localparam logic [2:0] ST_HALT = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    // Bits needed to hold 0..max_wait, never less than one.
    function automatic int timeout_cnt_w(input int max_wait);
        return (max_wait < 2) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts consecutive request cycles without an acknowledge and flags the
// cycle in which the count reaches MAX_WAIT. MAX_WAIT=0 disables the flag.
module fetch_timeout_ctr
    import s8sp_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = timeout_cnt_w(MAX_WAIT);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LIMIT)) begin
            r_cnt <= w_cnt_inc;
        end
    end

    // Fires in the cycle whose missing ack brings the count to MAX_WAIT, so the
    // FSM leaves after exactly MAX_WAIT unacknowledged request cycles.
    assign o_expired = (MAX_WAIT != 0) && i_en && (w_cnt_inc == LIMIT);

endmodule

// File: rtl/ir_fetch_ctrl.sv
// S8SP instruction-fetch sequencer: owns the PC, runs the memory req/ack
// handshake, strobes the IR and hands instructions to execute.
module ir_fetch_ctrl
    import s8sp_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [DATA_W-1:0] HALT_OP  = HALT_OP_DEF,
    parameter int                MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              load_ir,
    output logic [DATA_W-1:0] ir_data,
    output logic              ex_valid,
    input  logic              ex_done,
    input  logic              ex_branch,
    input  logic [ADDR_W-1:0] ex_target,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              fetch_err
);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic              w_expired;
    logic              w_enter_req;
    logic              w_cnt_en;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (run) w_state_nxt = ST_REQ;
            ST_REQ: begin
                // An ack in the last allowed cycle still wins over the timeout.
                if (mem_ack)        w_state_nxt = ST_LOAD;
                else if (w_expired) w_state_nxt = ST_ERR;
            end
            ST_LOAD: w_state_nxt = (r_ir == HALT_OP) ? ST_HALT : ST_EXEC;
            ST_EXEC: if (ex_done) w_state_nxt = run ? ST_REQ : ST_IDLE;
            ST_HALT, ST_ERR: w_state_nxt = r_state;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_enter_req = (w_state_nxt == ST_REQ) && (r_state != ST_REQ);
    assign w_cnt_en    = (r_state == ST_REQ) && !mem_ack;

    fetch_timeout_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timeout (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_clear   (w_enter_req),
        .i_en      (w_cnt_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_REQ) && mem_ack) begin
                r_ir <= mem_rdata;
            end
            // PC advances during LOAD, so execute already sees the next address.
            if (r_state == ST_LOAD) begin
                r_pc <= r_pc + 1'b1;
            end else if ((r_state == ST_EXEC) && ex_done && ex_branch) begin
                r_pc <= ex_target;
            end
        end
    end

    assign mem_req   = (r_state == ST_REQ);
    assign load_ir   = (r_state == ST_LOAD);
    assign ex_valid  = (r_state == ST_EXEC);
    assign halted    = (r_state == ST_HALT);
    assign fetch_err = (r_state == ST_ERR);
    assign mem_addr  = r_pc;
    assign pc        = r_pc;
    assign ir_data   = r_ir;

endmodule
